// File: rtl/vga_pkg.sv
// vga_pkg: shared encodings for the VGA pixel path blink control.
package vga_pkg;
  localparam logic [1:0] MODE_OFF     = 2'd0;
  localparam logic [1:0] MODE_STEADY  = 2'd1;
  localparam logic [1:0] MODE_BLINK   = 2'd2;
  localparam logic [1:0] MODE_ONESHOT = 2'd3;
  typedef enum logic [1:0] {ST_IDLE, ST_STEADY, ST_ON, ST_OFF} flash_state_t;
endpackage

// File: rtl/phase_counter.sv
// phase_counter: counts ticks within an ON or OFF phase and flags the last one.
module phase_counter #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic             i_inc,
  input  logic [CNT_W-1:0] i_len,
  output logic             o_term
);
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_eff;
  assign w_eff  = (i_len == '0) ? CNT_W'(1) : i_len;
  assign o_term = (r_cnt == w_eff);
  always_ff @(posedge clk or posedge reset)
    if (reset) r_cnt <= '0;
    else if (i_load) r_cnt <= CNT_W'(1);
    else if (i_inc) r_cnt <= r_cnt + 1'b1;
endmodule

// File: rtl/flash_sequencer.sv
// flash_sequencer: tick-driven off/steady/blink/one-shot sequencer whose
// visible output only changes at frame boundaries.
module flash_sequencer
  import vga_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_tick,
  input  logic             i_frame_start,
  input  logic [1:0]       i_mode,
  input  logic [CNT_W-1:0] i_on_len,
  input  logic [CNT_W-1:0] i_off_len,
  input  logic             i_trigger,
  output logic             o_flash_on,
  output logic             o_flash_raw,
  output logic             o_done
);
  flash_state_t     r_state, w_next, w_cap_state;
  logic [1:0]       r_mode;
  logic [CNT_W-1:0] r_on_len, r_off_len, w_len;
  logic             r_arm;
  logic             w_in_phase, w_term, w_end, w_capture, w_load, w_inc, w_arm_clr, w_done;
  phase_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk    (clk),
    .reset  (reset),
    .i_load (w_load),
    .i_inc  (w_inc),
    .i_len  (w_len),
    .o_term (w_term)
  );
  // Capture points sample the live inputs; ON/OFF run on the shadows only.
  always_comb begin
    w_in_phase  = (r_state == ST_ON) || (r_state == ST_OFF);
    w_len       = (r_state == ST_ON) ? r_on_len : r_off_len;
    w_end       = i_tick && w_in_phase && w_term;
    w_capture   = i_tick && (!w_in_phase || (r_state == ST_OFF && w_term));
    w_cap_state = (i_mode == MODE_OFF)    ? ST_IDLE :
                  (i_mode == MODE_STEADY) ? ST_STEADY :
                  (i_mode == MODE_BLINK || r_arm) ? ST_ON : ST_IDLE;
    w_next      = w_capture ? w_cap_state :
                  w_end     ? ((r_mode == MODE_ONESHOT) ? ST_IDLE : ST_OFF) : r_state;
    w_load      = (w_next != r_state) && (w_next == ST_ON || w_next == ST_OFF);
    w_inc       = i_tick && w_in_phase && !w_term;
    w_arm_clr   = w_capture && (i_mode == MODE_ONESHOT) && r_arm;
    w_done      = w_end && (r_state == ST_ON) && (r_mode == MODE_ONESHOT);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_state     <= ST_IDLE;
      r_arm       <= 1'b0;
      r_mode      <= MODE_OFF;
      r_on_len    <= '0;
      r_off_len   <= '0;
      o_flash_raw <= 1'b0;
      o_flash_on  <= 1'b0;
      o_done      <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_arm       <= i_trigger || (r_arm && !w_arm_clr);
      o_flash_raw <= (w_next == ST_STEADY) || (w_next == ST_ON);
      o_done      <= w_done;
      if (w_capture) begin
        r_mode    <= i_mode;
        r_on_len  <= i_on_len;
        r_off_len <= i_off_len;
      end
      if (i_frame_start) o_flash_on <= o_flash_raw;
    end
endmodule
